// File: rtl/div16_112_pkg.sv
// Shared arithmetic definitions for the 16-bit
// non-restoring divider: widths, iteration count, states.
package div16_112_pkg;

   localparam int WIDTH = 16;
   localparam int ITER  = 16;
   localparam int PW    = WIDTH + 1;
   localparam int CW    = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

   localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

endpackage

// File: rtl/div16_112_addsub17.sv
// 17-bit adder/subtractor shared by the iteration
// and the final remainder correction.
module addsub17_112
   import div16_112_pkg::*;
(
   input  logic [PW-1:0] a_i,
   input  logic [PW-1:0] b_i,
   input  logic          sub_i,
   output logic [PW-1:0] y_o
);

   logic [PW-1:0] b_x;

   // Two's-complement subtract via invert plus carry-in.
   always_comb begin
      b_x = b_i ^ {PW{sub_i}};
      y_o = a_i + b_x + {{(PW-1){1'b0}}, sub_i};
   end

endmodule

// File: rtl/div16_112.sv
// Sequential unsigned 16-bit divider, one quotient
// bit per cycle, with divide-by-zero short cut.
module div16_112
   import div16_112_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   div_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [PW-1:0]    as_a;
   logic [PW-1:0]    as_b;
   logic             as_sub;
   logic [PW-1:0]    as_y;

   addsub17_112 u_addsub (
      .a_i   (as_a),
      .b_i   (as_b),
      .sub_i (as_sub),
      .y_o   (as_y)
   );

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   // Next state, iteration step and result loading.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = (state_q == S_DONE);
      // Iteration: shift {P,A} left, then add/sub by old sign.
      as_a    = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
      as_b    = {1'b0, b_q};
      as_sub  = ~p_q[PW-1];

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  a_d     = dividend;
                  b_d     = divisor;
                  p_d     = '0;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            p_d = as_y;
            a_d = {a_q[WIDTH-2:0], ~as_y[PW-1]};
            if (cnt_q == LAST_ITER) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_FIX: begin
            // Negative partial remainder gets the divisor added back.
            as_a    = p_q;
            as_sub  = 1'b0;
            quo_d   = a_q;
            rem_d   = p_q[PW-1] ? as_y[WIDTH-1:0]
                                : p_q[WIDTH-1:0];
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign done        = done_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_div16_112.sv
// Directed bench for div16_112: results, latency,
// divide-by-zero, ignored starts and mid-run reset.
module tb_div16_112;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int n_chk;
   int n_bad;
   int done_cnt;
   int snap;

   div16_112 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Start at a negedge, wait for done, check everything.
   // Returns at the negedge of the done cycle.
   task automatic run_div(input string tag,
                          input logic [15:0] dd,
                          input logic [15:0] dv,
                          input logic [15:0] eq,
                          input logic [15:0] er,
                          input logic        ez,
                          input int          elat,
                          input bit          intr);
      int lat;
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = intr && (lat == 5);
         if (start) begin
            dividend = 16'd50;
            divisor  = 16'd5;
         end
      end
      start = 1'b0;
      chk({tag, "_lat"}, 32'(lat), 32'(elat));
      chk({tag, "_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_r"}, 32'(remainder), 32'(er));
      chk({tag, "_z"}, 32'(div_by_zero), 32'(ez));
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_chk    = 0;
      n_bad    = 0;
      done_cnt = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_q", 32'(quotient), 32'd0);
      chk("rst_r", 32'(remainder), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_z", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 18, 1'b0);
      @(negedge clk);
      chk("pulse_w", 32'(done), 32'd0);
      chk("hold_q", 32'(quotient), 32'd14);

      run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 18, 1'b0);
      run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 18, 1'b0);
      run_div("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 18, 1'b0);
      run_div("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 18, 1'b0);
      run_div("d12345_123", 16'd12345, 16'd123, 16'd100, 16'd45, 1'b0, 18, 1'b0);
      run_div("dffff_256", 16'hFFFF, 16'd256, 16'd255, 16'd255, 1'b0, 18, 1'b0);

      run_div("dbz", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 1'b0);
      run_div("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 18, 1'b0);
      repeat (5) @(negedge clk);
      chk("hold_q2", 32'(quotient), 32'd3);
      chk("hold_r2", 32'(remainder), 32'd0);

      snap = done_cnt;
      run_div("d200_9", 16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 18, 1'b1);
      repeat (3) @(negedge clk);
      chk("one_pulse", 32'(done_cnt - snap), 32'd1);
      chk("ign_q", 32'(quotient), 32'd22);

      snap     = done_cnt;
      start    = 1'b1;
      dividend = 16'd1234;
      divisor  = 16'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_q", 32'(quotient), 32'd0);
      chk("mrst_r", 32'(remainder), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_z", 32'(div_by_zero), 32'd0);
      run_div("d1000_33", 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 18, 1'b0);
      chk("mrst_nodone", 32'(done_cnt - snap), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/div16_112.md
DIV16_112 -- requirements
Module: div16_112

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request a division, sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 16 bits: unsigned dividend, sampled with start.
REQ-005 SHALL have port divisor, input, 16 bits: unsigned divisor, sampled with start.
REQ-006 SHALL have port quotient, output, 16 bits: registered result quotient.
REQ-007 SHALL have port remainder, output, 16 bits: registered result remainder.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse, results valid.
REQ-010 SHALL have port div_by_zero, output, 1 bit: registered flag for the last division, 1 if divisor was 0.

Function
REQ-011 SHALL implement unsigned non-restoring division: dividend = quotient*divisor + remainder, remainder < divisor.
REQ-012 SHALL use a state machine with states IDLE, CALC, FIX, DONE.
REQ-013 SHALL, in IDLE with start=1 and divisor!=0, latch the operands, clear the 17-bit partial remainder, clear the iteration counter, and go to CALC.
REQ-014 SHALL, in CALC, perform one iteration per cycle: shift {partial remainder, quotient register} left by 1, then subtract divisor if the partial remainder is >= 0 or add divisor if it is < 0, then set quotient bit = NOT sign.
REQ-015 SHALL stay in CALC for exactly 16 cycles (counter 0..15), then go to FIX.
REQ-016 SHALL, in FIX, add divisor back if the partial remainder is negative, then load quotient and remainder, then go to DONE.
REQ-017 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-018 SHALL give fixed latency: with start sampled at edge 0, done is high in the cycle after edge 18.
REQ-019 SHALL, in IDLE with start=1 and divisor=0, go directly to DONE with quotient=16'hFFFF, remainder=dividend and div_by_zero=1, so done is high in the cycle after edge 1.
REQ-020 SHALL clear div_by_zero on any accepted start with a nonzero divisor.
REQ-021 SHALL ignore start while busy=1, with no effect on the operation in flight.
REQ-022 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next accepted start.
REQ-023 SHALL accept a start asserted in the IDLE cycle immediately after DONE, giving back-to-back operation.
REQ-024 SHALL compute the partial remainder in 17 bits so that dividend=16'hFFFF with divisor=16'hFFFF or divisor=1 does not overflow.

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, go to IDLE and zero quotient, remainder, busy, done, div_by_zero, the counter and all internal registers.
REQ-026 SHALL, on reset mid-operation (CALC or FIX), abort with no done pulse, and SHALL accept a new start on the first edge with rst_n=1.

Structure
REQ-027 SHALL place the state encodings, WIDTH=16 and ITER=16 in the shared arithmetic definitions header used by the arithmetic blocks.
REQ-028 SHALL instantiate exactly one combinational sub-module, addsub17_112 (17-bit add/subtract selected by a sub input), for both the CALC and FIX operations.

Verification
REQ-029 SHALL cover: dividend=100, divisor=7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 18 cycles after start.
REQ-030 SHALL cover: dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; then dividend=16'hFFFF, divisor=16'hFFFF -> quotient=1, remainder=0.
REQ-031 SHALL cover: dividend=3, divisor=10 -> quotient=0, remainder=3; and dividend=0, divisor=5 -> quotient=0, remainder=0.
REQ-032 SHALL cover: dividend=5, divisor=0 -> done after 1 cycle, quotient=16'hFFFF, remainder=5, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-033 SHALL cover: start 200/9, then start 50/5 pulsed mid-CALC -> only 22 r 2 is produced, with a single done pulse.
REQ-034 SHALL cover: rst_n=0 at CALC iteration 8 -> no done pulse, all outputs 0; then 1000/33 -> quotient=30, remainder=10.
